mode_controller: RTL

MODE_CONTROLLER -- requirements
Module: mode_controller

---
 rtl/mode_controller_if.sv | 28 ++
 rtl/mode_controller.sv | 105 ++++++++++
 2 files changed

// File: rtl/mode_controller_if.sv
// Button inputs and LED-processor control bus for mode_controller.
// The controller drives the master side; the LED processors or a bench use the slave side.
interface mode_controller_if;
  logic       btn_mode;
  logic       btn_pause;
  logic       tick;
  logic       pause;
  logic [1:0] mode;
  logic       mode_clr;

  modport master (
    input  btn_mode,
    input  btn_pause,
    output tick,
    output pause,
    output mode,
    output mode_clr
  );

  modport slave (
    output btn_mode,
    output btn_pause,
    input  tick,
    input  pause,
    input  mode,
    input  mode_clr
  );
endinterface

// File: rtl/mode_controller.sv
// Two debounced push-buttons select the LED mode and freeze/resume the pattern,
// and a divider produces the step tick for the LED mode processors.
module mode_controller #(
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_MODES       = 4
) (
  input  logic              clk,
  input  logic              reset,
  mode_controller_if.master bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);

  typedef enum logic {
    RUNNING,
    PAUSED
  } state_t;

  // bit 0 = mode button, bit 1 = pause button
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_prev;
  logic [1:0]    press;
  logic [DW-1:0] cnt [2];

  state_t        state;
  logic [TW-1:0] div_cnt;

  assign raw = {bus.btn_pause, bus.btn_mode};

  // Synchronize, debounce and edge-detect both buttons; a level change is
  // accepted only after it has differed from the debounced level for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A mode press outranks a pause press: it advances the mode, resumes the
  // pattern and restarts the tick period, so tick cannot coincide with mode_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUNNING;
      div_cnt      <= '0;
      bus.tick     <= 1'b0;
      bus.pause    <= 1'b0;
      bus.mode     <= 2'd0;
      bus.mode_clr <= 1'b0;
    end else begin
      bus.tick     <= 1'b0;
      bus.mode_clr <= 1'b0;
      if (press[0]) begin
        bus.mode     <= (bus.mode == MODE_LAST) ? 2'd0 : bus.mode + 2'd1;
        state        <= RUNNING;
        bus.pause    <= 1'b0;
        div_cnt      <= '0;
        bus.mode_clr <= 1'b1;
      end else begin
        if (state == RUNNING) begin
          if (div_cnt == TICK_LAST) begin
            div_cnt  <= '0;
            bus.tick <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        if (press[1]) begin
          state     <= (state == RUNNING) ? PAUSED : RUNNING;
          bus.pause <= (state == RUNNING);
        end
      end
    end
  end

endmodule
